// File: rtl/stream_block_source.sv
// stream_block_source: seeded counting AXI-stream source emitting SDIM blocks of BDIM beats per frame
module stream_block_source #(
   parameter int m_axis_output_BDIM = 16,
   parameter int m_axis_output_SDIM = 256,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   input  logic                  ap_start,
   input  logic [DATA_WIDTH-1:0] seed,
   input  logic [3:0]            idle_gap,
   output logic                  ap_idle,
   output logic                  ap_done,
   output logic [DATA_WIDTH-1:0] m_axis_output_tdata,
   output logic                  m_axis_output_tvalid,
   input  logic                  m_axis_output_tready,
   output logic                  m_axis_output_tlast
);
   localparam int BW = m_axis_output_BDIM > 1 ? $clog2(m_axis_output_BDIM) : 1;
   localparam int KW = m_axis_output_SDIM > 1 ? $clog2(m_axis_output_SDIM) : 1;
   localparam logic [BW-1:0] BEAT_LAST = BW'(m_axis_output_BDIM - 1);
   localparam logic [KW-1:0] BLK_LAST = KW'(m_axis_output_SDIM - 1);
   typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
   state_t state, state_d;
   logic [BW-1:0] beat, beat_d;
   logic [KW-1:0] blk, blk_d;
   logic [3:0] gap_n, gap_n_d, gap_cnt, gap_cnt_d;
   logic [DATA_WIDTH-1:0] data_d;
   logic xfer, final_beat;
   assign xfer = m_axis_output_tvalid && m_axis_output_tready;
   assign final_beat = m_axis_output_tlast && blk == BLK_LAST;
   // state, counters and all outputs registered; outputs follow the next state
   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         state <= IDLE;
         beat <= '0;
         blk <= '0;
         gap_n <= '0;
         gap_cnt <= '0;
         m_axis_output_tdata <= '0;
         m_axis_output_tvalid <= 1'b0;
         m_axis_output_tlast <= 1'b0;
         ap_done <= 1'b0;
         ap_idle <= 1'b1;
      end else begin
         state <= state_d;
         beat <= beat_d;
         blk <= blk_d;
         gap_n <= gap_n_d;
         gap_cnt <= gap_cnt_d;
         m_axis_output_tdata <= data_d;
         m_axis_output_tvalid <= state_d == RUN;
         m_axis_output_tlast <= state_d == RUN && beat_d == BEAT_LAST;
         ap_done <= state_d == DONE;
         ap_idle <= state_d == IDLE;
      end
   // next state: start from IDLE, leave RUN only on a transfer, GAP counts down
   always_comb begin
      state_d = state;
      case (state)
         IDLE: if (ap_start) state_d = RUN;
         RUN: if (xfer) state_d = final_beat ? DONE : (gap_n != 0 ? GAP : RUN);
         GAP: if (gap_cnt == 4'd1) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end
   // next counter/data values: latch at start, advance on each transfer
   always_comb begin
      beat_d = beat;
      blk_d = blk;
      gap_n_d = gap_n;
      data_d = m_axis_output_tdata;
      gap_cnt_d = state == GAP ? gap_cnt - 4'd1 : gap_n;
      if (state == IDLE && ap_start) begin
         beat_d = '0;
         blk_d = '0;
         gap_n_d = idle_gap;
         data_d = seed;
      end else if (xfer) begin
         beat_d = beat == BEAT_LAST ? '0 : beat + BW'(1);
         blk_d = beat == BEAT_LAST ? blk + KW'(1) : blk;
         data_d = m_axis_output_tdata + DATA_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_stream_block_source.sv
// tb_stream_block_source: frame table, random backpressure, reset and BDIM=1 restart checks
module tb_stream_block_source;
   logic clk = 0, rst_n = 1, start = 0, tready = 0;
   logic [31:0] seed = 0;
   logic [3:0] gap = 0;
   logic idle, done, tvalid, tlast;
   logic [31:0] tdata;
   logic start2 = 0, tready2 = 1;
   logic [31:0] seed2 = 0;
   logic [3:0] gap2 = 0;
   logic idle2, done2, tvalid2, tlast2;
   logic [31:0] tdata2;
   int checks = 0, errors = 0;
   typedef struct {
      logic [31:0] seed;
      logic [3:0]  gap;
      bit          rnd;
      logic [31:0] first;
      logic [31:0] last;
   } vec_t;
   vec_t vt[7];
   always #5 clk = ~clk;
   stream_block_source #(.m_axis_output_BDIM(4), .m_axis_output_SDIM(2), .DATA_WIDTH(32)) dut (
      .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start), .seed(seed), .idle_gap(gap),
      .ap_idle(idle), .ap_done(done), .m_axis_output_tdata(tdata),
      .m_axis_output_tvalid(tvalid), .m_axis_output_tready(tready), .m_axis_output_tlast(tlast));
   stream_block_source #(.m_axis_output_BDIM(1), .m_axis_output_SDIM(3), .DATA_WIDTH(32)) dut1 (
      .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start2), .seed(seed2), .idle_gap(gap2),
      .ap_idle(idle2), .ap_done(done2), .m_axis_output_tdata(tdata2),
      .m_axis_output_tvalid(tvalid2), .m_axis_output_tready(tready2), .m_axis_output_tlast(tlast2));
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
      end
   endtask
   // one 8-beat frame; expected beat i is seed+i with tlast on every 4th beat
   task automatic run_frame(input logic [31:0] s, input logic [3:0] g, input bit rnd,
                            output logic [31:0] first, output logic [31:0] last);
      int n = 0, low = 0, cyc = 0;
      bit gap_seen = 1, hold = 0, early = 0;
      logic [31:0] pd = 0;
      logic pl = 0;
      first = 'x;
      last = 'x;
      seed = s;
      gap = g;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      check("start_valid", tvalid, 1);
      check("start_idle", idle, 0);
      while (n < 8 && cyc < 400) begin
         if (hold) begin
            check("hold_valid", tvalid, 1);
            check("hold_data", tdata, pd);
            check("hold_last", tlast, pl);
         end
         if (done) early = 1;
         if (!tvalid) low++;
         else if (!gap_seen) begin
            check("gap_len", low, g);
            gap_seen = 1;
         end
         tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         hold = tvalid && !tready;
         pd = tdata;
         pl = tlast;
         if (tvalid && tready) begin
            check("beat_data", tdata, s + 32'(n));
            check("beat_last", tlast, 32'((n % 4) == 3));
            if (n == 0) first = tdata;
            last = tdata;
            n++;
            low = 0;
            gap_seen = 0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      check("beats", n, 8);
      check("early_done", early, 0);
      check("done_pulse", done, 1);
      check("done_valid", tvalid, 0);
      check("done_last", tlast, 0);
      check("done_idle", idle, 0);
      @(posedge clk); #1;
      check("done_clear", done, 0);
      check("back_idle", idle, 1);
   endtask
   initial begin
      logic [31:0] f, l, s;
      int d, v, k;
      vt[0] = '{32'h10, 4'd0, 1'b0, 32'h10, 32'h17};
      vt[1] = '{32'h10, 4'd0, 1'b1, 32'h10, 32'h17};
      vt[2] = '{32'h10, 4'd3, 1'b0, 32'h10, 32'h17};
      vt[3] = '{32'hFFFFFFFE, 4'd0, 1'b0, 32'hFFFFFFFE, 32'h5};
      vt[4] = '{32'h10, 4'd3, 1'b1, 32'h10, 32'h17};
      for (int i = 5; i < 7; i++) begin
         s = $urandom;
         vt[i] = '{s, 4'($urandom_range(0, 5)), 1'b1, s, s + 32'd7};
      end
      #2 rst_n = 0;
      #1;
      check("rst_idle", idle, 1);
      check("rst_valid", tvalid, 0);
      check("rst_last", tlast, 0);
      check("rst_data", tdata, 0);
      check("rst_done", done, 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      check("rel_idle", idle, 1);
      for (int i = 0; i < 7; i++) begin
         run_frame(vt[i].seed, vt[i].gap, vt[i].rnd, f, l);
         check("first_word", f, vt[i].first);
         check("last_word", l, vt[i].last);
      end
      seed = 32'h30;
      gap = 0;
      tready = 1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("mid_data", tdata, 32'h33);
      #2 rst_n = 0;
      #1;
      check("mid_rst_valid", tvalid, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_idle", idle, 1);
      check("mid_rst_data", tdata, 0);
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_no_done", done, 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk); #1;
      check("post_rst_valid", tvalid, 0);
      run_frame(32'h20, 4'd0, 1'b0, f, l);
      check("restart_first", f, 32'h20);
      check("restart_last", l, 32'h27);
      seed2 = 32'h40;
      start2 = 1;
      d = -1;
      v = -1;
      k = 0;
      for (int c = 0; c < 20 && v < 0; c++) begin
         @(posedge clk); #1;
         if (tvalid2 && d < 0) begin
            check("b1_data", tdata2, 32'h40 + 32'(k));
            check("b1_last", tlast2, 1);
            k++;
         end
         if (done2 && d < 0) d = c;
         else if (d >= 0 && tvalid2 && v < 0) v = c;
      end
      start2 = 0;
      check("b1_beats", k, 3);
      check("b1_restart_gap", v - d, 2);
      check("b1_restart_data", tdata2, 32'h40);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule

// File: doc/stream_block_source.md
STREAM_BLOCK_SOURCE -- requirements
Module: stream_block_source

Interface
REQ-001 SHALL have parameter m_axis_output_BDIM, default 16: beats per block (>=1).
REQ-002 SHALL have parameter m_axis_output_SDIM, default 256: blocks per frame (>=1).
REQ-003 SHALL have parameter DATA_WIDTH, default 32: tdata width.
REQ-004 SHALL have port ap_clk  input  1: the single clock; all logic on rising edge.
REQ-005 SHALL have port ap_rst_n  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port ap_start  input  1: frame start request.
REQ-007 SHALL have port seed  input  DATA_WIDTH: first data word of a frame.
REQ-008 SHALL have port idle_gap  input  4: idle cycles inserted after each accepted beat.
REQ-009 SHALL have port ap_idle  output  1: high in IDLE.
REQ-010 SHALL have port ap_done  output  1: one-cycle frame-complete pulse.
REQ-011 SHALL have port m_axis_output_tdata  output  DATA_WIDTH: stream data.
REQ-012 SHALL have port m_axis_output_tvalid  output  1: stream valid.
REQ-013 SHALL have port m_axis_output_tready  input  1: stream ready from consumer.
REQ-014 SHALL have port m_axis_output_tlast  output  1: last beat of each BDIM block.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, GAP, DONE; all outputs registered.
REQ-016 SHALL, in IDLE with ap_start=1, latch seed and idle_gap, clear beat/block counters, and enter RUN next cycle; tvalid first high in the cycle after ap_start is sampled.
REQ-017 SHALL ignore ap_start in RUN, GAP and DONE; holding ap_start high after DONE starts a new frame from IDLE.
REQ-018 SHALL, in RUN, drive tvalid=1; a beat transfers on a rising edge with tvalid=1 and tready=1.
REQ-019 SHALL hold tdata and tlast stable and keep tvalid high until the transfer; tvalid never drops without a transfer.
REQ-020 SHALL drive tdata = latched seed + frame beat index (0..BDIM*SDIM-1), modulo 2^DATA_WIDTH (wraps silently).
REQ-021 SHALL drive tlast=1 exactly when in-block beat counter equals BDIM-1; with BDIM=1, tlast=1 on every beat.
REQ-022 SHALL size in-block counter to max(1,$clog2(BDIM)) bits and block counter to max(1,$clog2(SDIM)) bits; in-block counter wraps to 0 after BDIM-1 and block counter increments then.
REQ-023 SHALL, after a non-final transfer with latched idle_gap=N>0, enter GAP with tvalid=0 for exactly N cycles, then return to RUN; with N=0 stay in RUN (back-to-back beats, one per cycle under constant tready).
REQ-024 SHALL, on the transfer of the final beat (block SDIM-1, beat BDIM-1), enter DONE with tvalid=0, tlast=0; ap_done=1 for exactly that DONE cycle, then IDLE.
REQ-025 SHALL ignore tready while tvalid=0; tready toggling never changes tdata/tlast.
REQ-026 SHALL keep ap_idle=1 only in IDLE, 0 in RUN, GAP, DONE.

Reset
REQ-027 SHALL, on ap_rst_n=0 asynchronously and without a clock edge: state IDLE, tvalid=0, tlast=0, tdata=0, ap_done=0, ap_idle=1, counters and latched seed/idle_gap 0.
REQ-028 SHALL, on reset mid-frame, abandon the frame (no ap_done); the next ap_start after release begins a fresh frame at beat 0.
REQ-029 SHALL ignore ap_start in the first cycle after ap_rst_n deasserts only if sampled while reset is low; first valid sample is the first rising edge with ap_rst_n=1.

Verification
REQ-030 Bench params BDIM=4, SDIM=2; seed=0x10, idle_gap=0, tready=1 -> 8 beats 0x10..0x17 on consecutive cycles, tlast on 0x13 and 0x17, ap_done one cycle after 0x17 transfer.
REQ-031 Same, tready random 50% -> identical data/tlast sequence; tdata/tlast never change while tvalid=1 and tready=0.
REQ-032 idle_gap=3, tready=1 -> exactly 3 tvalid-low cycles between each of 8 beats; no gap after final beat.
REQ-033 seed=0xFFFFFFFE -> tdata 0xFFFFFFFE, 0xFFFFFFFF, 0x0, ..., 0x5; tlast on 0x1 and 0x5.
REQ-034 Assert ap_rst_n=0 between clock edges after beat 3 -> tvalid=0 immediately, no ap_done; restart seed=0x20 -> beats 0x20..0x27.
REQ-035 BDIM=1, SDIM=3, ap_start held high -> tlast on every beat; after ap_done, new frame begins with tvalid high two cycles after ap_done.
